// File: rtl/iguana_pkg.sv
// Shared types and pin constants for the iguana pad-side IO mux.
// Pin 0 is the USB-enable strap; USB pins start at pin 1.
package iguana_pkg;

   typedef enum logic [1:0] {
      IoMuxGpio,
      IoMuxToUsb,
      IoMuxUsb,
      IoMuxToGpio
   } io_mux_state_e;

   localparam int unsigned UsbSelPin  = 0;
   localparam int unsigned UsbPinBase = 1;

endpackage

// File: rtl/iguana_io_mux_debounce.sv
// Strap synchronizer plus stability counter.
// A new level is accepted after DebounceCycles consecutive mismatching cycles.
module iguana_io_mux_debounce #(
   parameter int unsigned SyncStages     = 2,
   parameter int unsigned DebounceCycles = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic test_mode_i,
   input  logic pad_i,
   output logic deb_o
);

   localparam int unsigned CntW = $clog2(DebounceCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(DebounceCycles);

   logic [SyncStages-1:0] r_sync;
   logic [CntW-1:0]       r_cnt;
   logic                  r_deb;
   logic                  w_sel;
   logic                  w_diff;
   logic                  w_accept;

   assign w_sel    = r_sync[SyncStages-1];
   assign w_diff   = w_sel ^ r_deb;
   assign w_accept = w_diff & (test_mode_i | (r_cnt == CntLast));
   assign deb_o    = r_deb;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync <= '0;
      end else begin
         r_sync[0] <= pad_i;
         for (int i = 1; i < int'(SyncStages); i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   // Any cycle without a mismatch restarts the stability count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
         r_deb <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_deb <= w_sel;
      end else if (w_diff) begin
         if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

endmodule

// File: rtl/iguana_io_mux.sv
// Pad-side GPIO/USB mux with debounced strap and tristate guard on switch.
// Optional IGUANA_IO_MUX_OVERRIDE_EN adds a SoC register override of the strap.
module iguana_io_mux
   import iguana_pkg::*;
#(
   parameter int unsigned NumGpio        = 32,
   parameter int unsigned UsbNumPorts    = 2,
   parameter int unsigned SyncStages     = 2,
   parameter int unsigned DebounceCycles = 1024,
   parameter int unsigned GuardCycles    = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   test_mode_i,
   input  logic [NumGpio-1:0]     pad_gpio_i,
   output logic [NumGpio-1:0]     pad_gpio_o,
   output logic [NumGpio-1:0]     pad_gpio_en_o,
   output logic [NumGpio-1:0]     soc_gpio_i,
   input  logic [NumGpio-1:0]     soc_gpio_o,
   input  logic [NumGpio-1:0]     soc_gpio_en_o,
   output logic [UsbNumPorts-1:0] usb_dm_i,
   output logic [UsbNumPorts-1:0] usb_dp_i,
   input  logic [UsbNumPorts-1:0] usb_dm_o,
   input  logic [UsbNumPorts-1:0] usb_dp_o,
   input  logic [UsbNumPorts-1:0] usb_dm_oe_o,
   input  logic [UsbNumPorts-1:0] usb_dp_oe_o,
`ifdef IGUANA_IO_MUX_OVERRIDE_EN
   input  logic                   ovr_en_i,
   input  logic                   ovr_sel_i,
`endif
   output logic                   usb_mode_o
);

   localparam int unsigned GW = $clog2(GuardCycles + 1);
   localparam logic [GW-1:0] GLast = GW'(GuardCycles - 1);
   localparam logic [GW-1:0] GMax  = GW'(GuardCycles);

   io_mux_state_e r_state;
   io_mux_state_e w_state_d;
   logic [GW-1:0] r_gcnt;
   logic [GW-1:0] w_gcnt_d;
   logic          w_deb;
   logic          w_sel;
   logic          w_done;

   iguana_io_mux_debounce #(
      .SyncStages     (SyncStages),
      .DebounceCycles (DebounceCycles)
   ) u_debounce (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .test_mode_i (test_mode_i),
      .pad_i       (pad_gpio_i[UsbSelPin]),
      .deb_o       (w_deb)
   );

`ifdef IGUANA_IO_MUX_OVERRIDE_EN
   assign w_sel = ovr_en_i ? ovr_sel_i : w_deb;
`else
   assign w_sel = w_deb;
`endif

   assign w_done     = test_mode_i | (r_gcnt == GLast);
   assign usb_mode_o = (r_state == IoMuxUsb);
   assign soc_gpio_i = pad_gpio_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IoMuxGpio;
         r_gcnt  <= '0;
      end else begin
         r_state <= w_state_d;
         r_gcnt  <= w_gcnt_d;
      end
   end

   // A select reversal inside a guard restarts the guard toward the new side.
   always_comb begin
      w_state_d = r_state;
      w_gcnt_d  = r_gcnt;
      unique case (r_state)
         IoMuxGpio: begin
            if (w_sel) begin
               w_state_d = IoMuxToUsb;
               w_gcnt_d  = '0;
            end
         end
         IoMuxToUsb: begin
            if (!w_sel) begin
               w_state_d = IoMuxToGpio;
               w_gcnt_d  = '0;
            end else if (w_done) begin
               w_state_d = IoMuxUsb;
               w_gcnt_d  = '0;
            end else if (r_gcnt != GMax) begin
               w_gcnt_d = r_gcnt + 1'b1;
            end
         end
         IoMuxUsb: begin
            if (!w_sel) begin
               w_state_d = IoMuxToGpio;
               w_gcnt_d  = '0;
            end
         end
         IoMuxToGpio: begin
            if (w_sel) begin
               w_state_d = IoMuxToUsb;
               w_gcnt_d  = '0;
            end else if (w_done) begin
               w_state_d = IoMuxGpio;
               w_gcnt_d  = '0;
            end else if (r_gcnt != GMax) begin
               w_gcnt_d = r_gcnt + 1'b1;
            end
         end
         default: begin
            w_state_d = IoMuxGpio;
            w_gcnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      pad_gpio_o    = soc_gpio_o;
      pad_gpio_en_o = soc_gpio_en_o;
      usb_dm_i      = '0;
      usb_dp_i      = '1;
      unique case (r_state)
         IoMuxToUsb, IoMuxToGpio: begin
            for (int s = 0; s < int'(2 * UsbNumPorts); s++) begin
               pad_gpio_o[UsbPinBase+s]    = 1'b0;
               pad_gpio_en_o[UsbPinBase+s] = 1'b0;
            end
         end
         IoMuxUsb: begin
            for (int p = 0; p < int'(UsbNumPorts); p++) begin
               pad_gpio_o[UsbPinBase+2*p]      = usb_dm_o[p];
               pad_gpio_o[UsbPinBase+2*p+1]    = usb_dp_o[p];
               pad_gpio_en_o[UsbPinBase+2*p]   = usb_dm_oe_o[p];
               pad_gpio_en_o[UsbPinBase+2*p+1] = usb_dp_oe_o[p];
               usb_dm_i[p] = pad_gpio_i[UsbPinBase+2*p];
               usb_dp_i[p] = pad_gpio_i[UsbPinBase+2*p+1];
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_iguana_io_mux.sv
// Directed + random bench for iguana_io_mux against a window/guard model.
// Two instances: (Deb 8, Guard 4) and (Deb 2, Guard 8) to reach guard aborts.
module tb_iguana_io_mux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tm = 1'b0;
   logic [31:0] pad_i = '0;
   logic [31:0] soc_o = '0;
   logic [31:0] soc_en = '0;
   logic [1:0]  dm_o = '0, dp_o = '0, dm_oe = '0, dp_oe = '0;
`ifdef IGUANA_IO_MUX_OVERRIDE_EN
   logic        ovr_en = 1'b0;
   logic        ovr_sel = 1'b0;
`endif

   logic [31:0] pad_o1, en1, si1, pad_o2, en2, si2;
   logic [1:0]  dmi1, dpi1, dmi2, dpi2;
   logic        mode1, mode2;

   int total = 0;
   int bad = 0;
   bit keep_en = 1'b0;

   localparam int SYN = 2;
   int dcy[2] = '{8, 2};
   int gcy[2] = '{4, 8};

   // model: st 0 = GPIO, 1 = USB, 2 = guard toward tgt
   bit hist[$];
   bit m_deb[2];
   int m_st[2];
   bit m_tgt[2];
   int m_left[2];

   always #5 clk = ~clk;

   iguana_io_mux #(
      .NumGpio(32), .UsbNumPorts(2), .SyncStages(2),
      .DebounceCycles(8), .GuardCycles(4)
   ) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .test_mode_i(tm),
      .pad_gpio_i(pad_i), .pad_gpio_o(pad_o1), .pad_gpio_en_o(en1),
      .soc_gpio_i(si1), .soc_gpio_o(soc_o), .soc_gpio_en_o(soc_en),
      .usb_dm_i(dmi1), .usb_dp_i(dpi1),
      .usb_dm_o(dm_o), .usb_dp_o(dp_o),
      .usb_dm_oe_o(dm_oe), .usb_dp_oe_o(dp_oe),
`ifdef IGUANA_IO_MUX_OVERRIDE_EN
      .ovr_en_i(ovr_en), .ovr_sel_i(ovr_sel),
`endif
      .usb_mode_o(mode1)
   );

   iguana_io_mux #(
      .NumGpio(32), .UsbNumPorts(2), .SyncStages(2),
      .DebounceCycles(2), .GuardCycles(8)
   ) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .test_mode_i(tm),
      .pad_gpio_i(pad_i), .pad_gpio_o(pad_o2), .pad_gpio_en_o(en2),
      .soc_gpio_i(si2), .soc_gpio_o(soc_o), .soc_gpio_en_o(soc_en),
      .usb_dm_i(dmi2), .usb_dp_i(dpi2),
      .usb_dm_o(dm_o), .usb_dp_o(dp_o),
      .usb_dm_oe_o(dm_oe), .usb_dp_oe_o(dp_oe),
`ifdef IGUANA_IO_MUX_OVERRIDE_EN
      .ovr_en_i(ovr_en), .ovr_sel_i(ovr_sel),
`endif
      .usb_mode_o(mode2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int u = 0; u < 2; u++) begin
         m_deb[u] = 1'b0;
         m_st[u] = 0;
         m_tgt[u] = 1'b0;
         m_left[u] = 0;
      end
   endtask

   // Strap level flips once the last D synchronized samples all differ.
   task automatic model_edge();
      int deff, geff, idx;
      bit flip, v, sel, cur;
      if (!rst_n) begin
         model_reset();
         return;
      end
      hist.push_back(pad_i[0]);
      for (int u = 0; u < 2; u++) begin
         deff = tm ? 1 : dcy[u];
         geff = tm ? 1 : gcy[u];
         flip = 1'b1;
         for (int j = 0; j < deff; j++) begin
            idx = hist.size() - 1 - SYN - j;
            v = (idx < 0) ? 1'b0 : hist[idx];
            if (v == m_deb[u]) flip = 1'b0;
         end
         sel = m_deb[u];
`ifdef IGUANA_IO_MUX_OVERRIDE_EN
         if (ovr_en) sel = ovr_sel;
`endif
         if (m_st[u] == 2) begin
            if (sel != m_tgt[u]) begin
               m_tgt[u] = sel;
               m_left[u] = geff;
            end else if (m_left[u] == 1) begin
               m_st[u] = m_tgt[u] ? 1 : 0;
            end else begin
               m_left[u]--;
            end
         end else begin
            cur = (m_st[u] == 1);
            if (sel != cur) begin
               m_st[u] = 2;
               m_tgt[u] = sel;
               m_left[u] = geff;
            end
         end
         if (flip) m_deb[u] = ~m_deb[u];
      end
   endtask

   task automatic check_all();
      logic [31:0] ep, ee;
      logic [1:0] edm, edp;
      for (int u = 0; u < 2; u++) begin
         ep = soc_o;
         ee = soc_en;
         edm = 2'b00;
         edp = 2'b11;
         if (m_st[u] == 2) begin
            ep[4:1] = 4'b0;
            ee[4:1] = 4'b0;
         end else if (m_st[u] == 1) begin
            ep[4:1] = {dp_o[1], dm_o[1], dp_o[0], dm_o[0]};
            ee[4:1] = {dp_oe[1], dm_oe[1], dp_oe[0], dm_oe[0]};
            edm = {pad_i[3], pad_i[1]};
            edp = {pad_i[4], pad_i[2]};
         end
         chk($sformatf("u%0d_pad_o", u), u == 0 ? pad_o1 : pad_o2, ep);
         chk($sformatf("u%0d_pad_en", u), u == 0 ? en1 : en2, ee);
         chk($sformatf("u%0d_soc_i", u), u == 0 ? si1 : si2, pad_i);
         chk($sformatf("u%0d_dm_i", u), 32'(u == 0 ? dmi1 : dmi2), 32'(edm));
         chk($sformatf("u%0d_dp_i", u), 32'(u == 0 ? dpi1 : dpi2), 32'(edp));
         chk($sformatf("u%0d_mode", u), 32'(u == 0 ? mode1 : mode2),
             32'(m_st[u] == 1));
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit p0);
      logic [31:0] w;
      w = $urandom;
      pad_i = {w[31:1], p0};
      soc_o = $urandom;
      soc_en = keep_en ? 32'hFFFF_FFFF : $urandom;
      dm_o = 2'($urandom);
      dp_o = 2'($urandom);
      dm_oe = 2'($urandom);
      dp_oe = 2'($urandom);
   endtask

   task automatic do_reset(input bit tmv);
      rst_n = 1'b0;
      model_reset();
      tm = tmv;
      drive(1'b0);
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      int rise, g, b3, lo, hi;
      bit lvl;

      // reset state
      model_reset();
      soc_o = 32'hA5A5_A5A5;
      soc_en = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("t1_pad_o", pad_o1, 32'hA5A5_A5A5);
      chk("t1_pad_en", en1, 32'hFFFF_FFFF);
      chk("t1_dp_i", 32'(dpi1), 32'h3);
      chk("t1_dm_i", 32'(dmi1), 32'h0);
      chk("t1_mode", 32'(mode1), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // strap rise: latency and guard width
      keep_en = 1'b1;
      rise = 0;
      g = 0;
      for (int i = 1; i <= 40; i++) begin
         drive(1'b1);
         cycle();
         if (rise == 0) begin
            if (mode1) rise = i;
            else if (en1[4:1] == 4'b0) g++;
         end
      end
      chk("t2_usb_edge", rise, 15);
      chk("t2_guard_len", g, 4);

      // USB receive routing
      pad_i[4:1] = 4'b1010;
      #1;
      chk("t5_dm_i_a", 32'(dmi1), 32'h0);
      chk("t5_dp_i_a", 32'(dpi1), 32'h3);
      chk("t5_soc_i_a", 32'(si1[4:1]), 32'hA);
      pad_i[4:1] = 4'b0101;
      #1;
      chk("t5_dm_i_b", 32'(dmi1), 32'h3);
      chk("t5_dp_i_b", 32'(dpi1), 32'h0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1);
         cycle();
      end

      // async reset in the USB->GPIO guard
      for (int i = 0; i < 12; i++) begin
         drive(1'b0);
         cycle();
      end
      chk("t6_guard_en", 32'(en1[4:1]), 32'h0);
      chk("t6_guard_mode", 32'(mode1), 32'h0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_rst_en", 32'(en1[4:1]), 32'(soc_en[4:1]));
      chk("t6_rst_pad_o", pad_o1, soc_o);
      chk("t6_rst_mode", 32'(mode1), 32'h0);
      do_reset(1'b0);
      keep_en = 1'b0;

      // short pulses never pass the debouncer of the first instance
      b3 = 0;
      for (int k = 0; k < 42; k++) begin
         drive((k % 7) < 5);
         cycle();
         if (mode1 || en1[4:1] != soc_en[4:1]) b3++;
      end
      chk("t3_stay_gpio", b3, 0);
      for (int i = 0; i < 30; i++) begin
         drive(1'b0);
         cycle();
      end

      // random bursts: guard restarts on the second instance
      for (int r = 0; r < 12; r++) begin
         hi = $urandom_range(3, 14);
         lo = $urandom_range(3, 14);
         for (int i = 0; i < hi; i++) begin drive(1'b1); cycle(); end
         for (int i = 0; i < lo; i++) begin drive(1'b0); cycle(); end
      end

      // test mode: one-cycle debounce and guard
      do_reset(1'b1);
      keep_en = 1'b1;
      rise = 0;
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1);
         cycle();
         if (rise == 0 && mode1) rise = i;
      end
      chk("tm_usb_edge", rise, 5);
      keep_en = 1'b0;
      lvl = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 3) == 0) lvl = ~lvl;
         drive(lvl);
         cycle();
      end

      // long random run in normal mode
      do_reset(1'b0);
      lvl = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 11) == 0) lvl = ~lvl;
         drive(lvl);
         cycle();
      end

`ifdef IGUANA_IO_MUX_OVERRIDE_EN
      do_reset(1'b0);
      ovr_en = 1'b1;
      ovr_sel = 1'b1;
      rise = 0;
      for (int i = 1; i <= 12; i++) begin
         drive(1'b0);
         cycle();
         if (rise == 0 && mode1) rise = i;
      end
      chk("ovr_usb_edge", rise, 5);
      ovr_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0);
         cycle();
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
